// File: rtl/menu_pkg.sv
// Shared types and constants for the game-and-watch main menu.
package menu_pkg;

  typedef enum logic {
    S_GAME  = 1'b0,
    S_LEVEL = 1'b1
  } menu_state_t;

  typedef enum logic [2:0] {
    SRC_NONE    = 3'd0,
    SRC_TILE    = 3'd1,
    SRC_NAME    = 3'd2,
    SRC_LVL     = 3'd3,
    SRC_LVL_SEL = 3'd4
  } pix_src_t;

  localparam int unsigned MENU_CODE = 1;
  localparam int unsigned GAME_BASE = 2;

endpackage

// File: rtl/menu_btn_edge.sv
// Rising-edge detector over a vector of debounced button levels.
module menu_btn_edge #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Level,
  output logic [WIDTH-1:0] Press
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) prev <= '0;
    else       prev <= Level;
  end

  assign Press = Level & ~prev;

endmodule

// File: rtl/menu_controller.sv
// Main-menu FSM (game then difficulty selection) and per-pixel sprite classifier.
module menu_controller
  import menu_pkg::*;
#(
  parameter int unsigned NUM_GAMES  = 3,
  parameter int unsigned NUM_LEVELS = 2,
  parameter int unsigned CHOICE_W   = 4,
  parameter int unsigned TILE_X0    = 20,
  parameter int unsigned TILE_Y0    = 80,
  parameter int unsigned TILE_W     = 80,
  parameter int unsigned TILE_H     = 80,
  parameter int unsigned TILE_PITCH = 100,
  parameter int unsigned LABEL_Y0   = 190,
  parameter int unsigned LABEL_H    = 10,
  parameter int unsigned LABEL_W    = 40
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic                Left,
  input  logic                Right,
  input  logic                Enter,
  input  logic                Esc,
  input  logic [8:0]          VGAx,
  input  logic [7:0]          VGAy,
  output logic [CHOICE_W-1:0] GameChoice,
  output logic                Launch,
  output logic [2:0]          PixSource,
  output logic [2:0]          PixTile,
  output logic [12:0]         PixIndex
);

  localparam logic [2:0]  GAME_LAST  = 3'(NUM_GAMES - 1);
  localparam logic [1:0]  LEVEL_LAST = 2'(NUM_LEVELS - 1);
  localparam logic [16:0] SEG_W      = 17'(LABEL_W / NUM_LEVELS);

  logic [3:0]  press;
  menu_state_t state;
  logic [2:0]  game;
  logic [1:0]  level;

  menu_btn_edge #(.WIDTH(4)) u_btn_edge (
    .Clock (Clock),
    .Reset (Reset),
    .Level ({Left, Right, Enter, Esc}),
    .Press (press)
  );

  // press[3..0] = Left, Right, Enter, Esc; if/else order gives the priority.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_GAME;
      game       <= '0;
      level      <= '0;
      GameChoice <= CHOICE_W'(MENU_CODE);
      Launch     <= 1'b0;
    end else begin
      Launch <= 1'b0;
      if (!Enable) begin
        state <= S_GAME;
        game  <= '0;
        level <= '0;
      end else begin
        case (state)
          S_GAME: begin
            if (press[3])      game <= (game == '0) ? GAME_LAST : game - 3'd1;
            else if (press[2]) game <= (game == GAME_LAST) ? '0 : game + 3'd1;
            else if (press[1]) begin
              state <= S_LEVEL;
              level <= '0;
            end
          end
          S_LEVEL: begin
            if (press[3])      level <= (level == '0) ? LEVEL_LAST : level - 2'd1;
            else if (press[2]) level <= (level == LEVEL_LAST) ? '0 : level + 2'd1;
            else if (press[1]) begin
              GameChoice <= CHOICE_W'(GAME_BASE + 32'(game) * NUM_LEVELS + 32'(level));
              Launch     <= 1'b1;
              state      <= S_GAME;
              game       <= '0;
              level      <= '0;
            end else if (press[0]) begin
              state <= S_GAME;
              level <= '0;
            end
          end
          default: state <= S_GAME;
        endcase
      end
    end
  end

  logic [16:0] xw, yw, tx, lx;
  pix_src_t    src_n;
  logic [2:0]  tile_n;
  logic [12:0] idx_n;

  always_comb begin
    src_n  = SRC_NONE;
    tile_n = '0;
    idx_n  = '0;
    tx     = '0;
    lx     = '0;
    xw     = 17'(VGAx);
    yw     = 17'(VGAy);
    for (int unsigned i = 0; i < NUM_GAMES; i++) begin
      tx = 17'(TILE_X0 + i * TILE_PITCH);
      lx = 17'(TILE_X0 + 20 + i * TILE_PITCH);
      if (xw >= tx && xw < tx + 17'(TILE_W) &&
          yw >= 17'(TILE_Y0) && yw < 17'(TILE_Y0 + TILE_H)) begin
        src_n  = SRC_TILE;
        tile_n = 3'(i);
        idx_n  = 13'(17'(TILE_W) * (yw - 17'(TILE_Y0)) + (xw - tx));
      end else if (3'(i) == game && xw >= lx && xw < lx + 17'(LABEL_W) &&
                   yw >= 17'(LABEL_Y0) && yw < 17'(LABEL_Y0 + LABEL_H)) begin
        tile_n = 3'(i);
        idx_n  = 13'(17'(LABEL_W) * (yw - 17'(LABEL_Y0)) + (xw - lx));
        if (state == S_GAME)                       src_n = SRC_NAME;
        else if ((xw - lx) / SEG_W == 17'(level))  src_n = SRC_LVL_SEL;
        else                                       src_n = SRC_LVL;
      end
    end
    if (!Enable) begin
      src_n  = SRC_NONE;
      tile_n = '0;
      idx_n  = '0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      PixSource <= SRC_NONE;
      PixTile   <= '0;
      PixIndex  <= '0;
    end else begin
      PixSource <= src_n;
      PixTile   <= tile_n;
      PixIndex  <= idx_n;
    end
  end

endmodule

// File: tb/tb_menu_controller.sv
// Bench for menu_controller: directed vector table, randomized run against a model, async-reset sequence.
module tb_menu_controller;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        rst_a, en_a, la_a;
  logic [3:0]  b_a, gc_a;
  logic [8:0]  x_a;
  logic [7:0]  y_a;
  logic [2:0]  src_a, tile_a;
  logic [12:0] idx_a;

  logic        rst_b, en_b, la_b;
  logic [3:0]  b_b, gc_b;
  logic [8:0]  x_b;
  logic [7:0]  y_b;
  logic [2:0]  src_b, tile_b;
  logic [12:0] idx_b;

  menu_controller u_dut_a (
    .Clock(Clock), .Reset(rst_a), .Enable(en_a),
    .Left(b_a[3]), .Right(b_a[2]), .Enter(b_a[1]), .Esc(b_a[0]),
    .VGAx(x_a), .VGAy(y_a),
    .GameChoice(gc_a), .Launch(la_a), .PixSource(src_a), .PixTile(tile_a), .PixIndex(idx_a)
  );

  menu_controller #(.NUM_GAMES(4), .NUM_LEVELS(3)) u_dut_b (
    .Clock(Clock), .Reset(rst_b), .Enable(en_b),
    .Left(b_b[3]), .Right(b_b[2]), .Enter(b_b[1]), .Esc(b_b[0]),
    .VGAx(x_b), .VGAy(y_b),
    .GameChoice(gc_b), .Launch(la_b), .PixSource(src_b), .PixTile(tile_b), .PixIndex(idx_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] b;
    int x, y, gc, la, src, tile, idx;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic en, input logic [3:0] b, input int x, input int y,
                     input int gc, input int la, input int src, input int tile, input int idx);
    vec_t v;
    v.en = en; v.b = b; v.x = x; v.y = y; v.gc = gc; v.la = la;
    v.src = src; v.tile = tile; v.idx = idx;
    vecs.push_back(v);
  endtask

  // Reference model for the default configuration (3 games, 2 levels).
  localparam int MG = 3;
  localparam int ML = 2;
  int         m_game, m_lvl, m_gc;
  bit         m_inlvl;
  logic [3:0] m_prev;

  task automatic model_pix(input bit en, input int x, input int y,
                           output int src, output int tile, output int idx);
    src = 0; tile = 0; idx = 0;
    if (!en) return;
    for (int i = 0; i < MG; i++) begin
      int tx, lx;
      tx = 20 + 100 * i;
      lx = 40 + 100 * i;
      if (x >= tx && x < tx + 80 && y >= 80 && y < 160) begin
        src = 1; tile = i; idx = (80 * (y - 80) + x - tx) % 8192;
      end else if (i == m_game && x >= lx && x < lx + 40 && y >= 190 && y < 200) begin
        tile = i;
        idx  = 40 * (y - 190) + x - lx;
        if (!m_inlvl)                          src = 2;
        else if ((x - lx) / (40 / ML) == m_lvl) src = 4;
        else                                   src = 3;
      end
    end
  endtask

  task automatic model_step(input bit en, input logic [3:0] b, output int la);
    logic [3:0] p;
    p = b & ~m_prev;
    m_prev = b;
    la = 0;
    if (!en) begin
      m_game = 0; m_lvl = 0; m_inlvl = 0;
    end else if (p[3]) begin
      if (m_inlvl) m_lvl = (m_lvl + ML - 1) % ML;
      else         m_game = (m_game + MG - 1) % MG;
    end else if (p[2]) begin
      if (m_inlvl) m_lvl = (m_lvl + 1) % ML;
      else         m_game = (m_game + 1) % MG;
    end else if (p[1]) begin
      if (m_inlvl) begin
        m_gc = 2 + m_game * ML + m_lvl;
        la = 1;
        m_game = 0; m_lvl = 0; m_inlvl = 0;
      end else begin
        m_inlvl = 1; m_lvl = 0;
      end
    end else if (p[0] && m_inlvl) begin
      m_inlvl = 0; m_lvl = 0;
    end
  endtask

  initial begin
    int es, et, ei, el;

    rst_a = 1'b1; en_a = 1'b1; b_a = '0; x_a = '0; y_a = '0;
    rst_b = 1'b1; en_b = 1'b0; b_b = '0; x_b = '0; y_b = '0;
    #1;
    chk("reset gc", int'(gc_a), 1);
    chk("reset launch", int'(la_a), 0);
    chk("reset src", int'(src_a), 0);
    chk("reset tile", int'(tile_a), 0);
    chk("reset idx", int'(idx_a), 0);
    cyc();
    rst_a = 1'b0;

    // en, {L,R,Ent,Esc}, x, y, GameChoice, Launch, PixSource, PixTile, PixIndex
    add(1, 4'h0,  20,  80, 1, 0, 1, 0,    0);
    add(1, 4'h4, 240, 190, 1, 0, 0, 0,    0);
    add(1, 4'h0, 240, 190, 1, 0, 0, 0,    0);
    add(1, 4'h4, 240, 190, 1, 0, 0, 0,    0);
    add(1, 4'h0, 240, 190, 1, 0, 2, 2,    0);
    add(1, 4'h4, 245, 195, 1, 0, 2, 2,  205);
    add(1, 4'h0,  40, 190, 1, 0, 2, 0,    0);
    add(1, 4'h2,  60, 190, 1, 0, 2, 0,   20);
    add(1, 4'h0,  60, 190, 1, 0, 3, 0,   20);
    add(1, 4'h4,  45, 191, 1, 0, 4, 0,   45);
    add(1, 4'h0,  45, 191, 1, 0, 3, 0,   45);
    add(1, 4'h2,  79, 199, 3, 1, 4, 0,  399);
    add(1, 4'h2, 100,  80, 3, 0, 0, 0,    0);
    add(1, 4'h0, 119, 159, 3, 0, 0, 0,    0);
    add(1, 4'h4, 120, 159, 3, 0, 1, 1, 6320);
    add(1, 4'h0,   0,   0, 3, 0, 0, 0,    0);
    add(1, 4'h4,   0,   0, 3, 0, 0, 0,    0);
    add(1, 4'h0,   0,   0, 3, 0, 0, 0,    0);
    add(1, 4'h2, 299,  80, 3, 0, 1, 2,   79);
    add(1, 4'h0, 260, 190, 3, 0, 3, 2,   20);
    add(1, 4'h1, 240, 190, 3, 0, 4, 2,    0);
    add(1, 4'h0, 240, 190, 3, 0, 2, 2,    0);
    add(1, 4'h2, 240, 190, 3, 0, 2, 2,    0);
    add(1, 4'h0, 240, 190, 3, 0, 4, 2,    0);
    add(1, 4'h9, 240, 190, 3, 0, 4, 2,    0);
    add(1, 4'h0, 240, 190, 3, 0, 3, 2,    0);
    add(0, 4'h0, 240, 190, 3, 0, 0, 0,    0);
    add(0, 4'h4, 240, 190, 3, 0, 0, 0,    0);
    add(1, 4'h4,  40, 190, 3, 0, 2, 0,    0);
    add(1, 4'h4, 140, 190, 3, 0, 0, 0,    0);
    add(1, 4'h0,  40, 190, 3, 0, 2, 0,    0);
    add(1, 4'h8,  40, 190, 3, 0, 2, 0,    0);
    add(1, 4'h0, 240, 190, 3, 0, 2, 2,    0);

    foreach (vecs[k]) begin
      en_a = vecs[k].en; b_a = vecs[k].b;
      x_a = 9'(vecs[k].x); y_a = 8'(vecs[k].y);
      cyc();
      chk($sformatf("row%0d gc", k), int'(gc_a), vecs[k].gc);
      chk($sformatf("row%0d launch", k), int'(la_a), vecs[k].la);
      chk($sformatf("row%0d src", k), int'(src_a), vecs[k].src);
      if (vecs[k].src != 0) begin
        chk($sformatf("row%0d tile", k), int'(tile_a), vecs[k].tile);
        chk($sformatf("row%0d idx", k), int'(idx_a), vecs[k].idx);
      end
    end

    // Randomized run against the model from a fresh reset.
    rst_a = 1'b1; b_a = '0; en_a = 1'b1;
    cyc();
    rst_a = 1'b0;
    m_game = 0; m_lvl = 0; m_inlvl = 0; m_gc = 1; m_prev = '0;
    for (int n = 0; n < 600; n++) begin
      en_a = ($urandom_range(0, 15) != 0);
      b_a  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      x_a  = 9'($urandom_range(0, 319));
      y_a  = 8'($urandom_range(60, 210));
      model_pix(en_a, int'(x_a), int'(y_a), es, et, ei);
      model_step(en_a, b_a, el);
      cyc();
      chk($sformatf("rnd%0d gc", n), int'(gc_a), m_gc);
      chk($sformatf("rnd%0d launch", n), int'(la_a), el);
      chk($sformatf("rnd%0d src", n), int'(src_a), es);
      if (es != 0) begin
        chk($sformatf("rnd%0d tile", n), int'(tile_a), et);
        chk($sformatf("rnd%0d idx", n), int'(idx_a), ei);
      end
    end

    // 4 games x 3 levels: launch code 13, then async reset mid-period in S_LEVEL.
    en_b = 1'b1; x_b = 9'd20; y_b = 8'd80;
    cyc();
    rst_b = 1'b0;
    cyc();
    chk("b tile0 src", int'(src_b), 1);
    b_b = 4'h8; cyc();
    b_b = 4'h0; x_b = 9'd340; y_b = 8'd190; cyc();
    cyc();
    chk("b game3 label src", int'(src_b), 2);
    chk("b game3 label tile", int'(tile_b), 3);
    b_b = 4'h2; cyc();
    b_b = 4'h0; cyc();
    b_b = 4'h8; cyc();
    b_b = 4'h0; x_b = 9'd366; cyc();
    cyc();
    chk("b level2 seg src", int'(src_b), 4);
    chk("b level2 seg idx", int'(idx_b), 26);
    b_b = 4'h2; cyc();
    chk("b launch gc", int'(gc_b), 13);
    chk("b launch pulse", int'(la_b), 1);
    b_b = 4'h0; cyc();
    chk("b launch end", int'(la_b), 0);
    chk("b gc hold", int'(gc_b), 13);
    b_b = 4'h2; cyc();
    b_b = 4'h0; x_b = 9'd20; y_b = 8'd80; cyc();
    chk("b pre-reset src", int'(src_b), 1);
    #4;
    rst_b = 1'b1;
    #1;
    chk("b async gc", int'(gc_b), 1);
    chk("b async launch", int'(la_b), 0);
    chk("b async src", int'(src_b), 0);
    chk("b async tile", int'(tile_b), 0);
    chk("b async idx", int'(idx_b), 0);
    rst_b = 1'b0; x_b = 9'd40; y_b = 8'd190;
    cyc();
    chk("b post-reset name src", int'(src_b), 2);
    chk("b post-reset name tile", int'(tile_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/menu_controller.md
# menu_controller

Parametrised main-menu controller for the game-and-watch front end. It walks the player through game selection and then difficulty selection for `NUM_GAMES` games with `NUM_LEVELS` difficulties each, and reports the launched game on `GameChoice`. It also classifies each scanned VGA pixel into a sprite source and address for the downstream sprite ROMs and colour mux. It sits between the button debouncers and the top-level game arbiter, and is active only while `Enable` is high.

## Interface
- `NUM_GAMES`, 3, number of selectable games (2..8)
- `NUM_LEVELS`, 2, difficulties per game (2..4)
- `CHOICE_W`, 4, width of `GameChoice`
- `TILE_X0` / `TILE_Y0`, 20 / 80, top-left corner of game tile 0
- `TILE_W` / `TILE_H` / `TILE_PITCH`, 80 / 80 / 100, tile size and horizontal spacing
- `LABEL_Y0` / `LABEL_H` / `LABEL_W`, 190 / 10 / 40, label row y, label height and width; x offset is `TILE_X0 + 20 + i*TILE_PITCH`
- `Clock` in 1: system clock
- `Reset` in 1: asynchronous, active-high reset
- `Enable` in 1: menu owns the buttons and screen
- `Left`, `Right`, `Enter`, `Esc` in 1 each: debounced button levels
- `VGAx` in 9, `VGAy` in 8: current scan pixel
- `GameChoice` out `CHOICE_W`: `MENU_CODE` (1) while in the menu, otherwise the launched game/level code
- `Launch` out 1: one-cycle pulse when `GameChoice` takes a new game code
- `PixSource` out 3: sprite source for the pixel
- `PixTile` out 3: game index the pixel belongs to
- `PixIndex` out 13: ROM address within that source

## Operation
- **Button presses.** A press is a rising edge of a button level: current level high and previous sampled level low. The previous-level registers update every cycle, including while `Enable` is low, so a button held across a rising edge of `Enable` does not fire.
- **Press priority.** When several presses occur in one cycle, only the highest-priority one acts: Left > Right > Enter > Esc.
- **States:** `S_GAME`, `S_LEVEL`.
- **`S_GAME`:**
  - Left: `game` decrements, wrapping 0 to `NUM_GAMES-1`.
  - Right: `game` increments, wrapping `NUM_GAMES-1` to 0.
  - Enter: go to `S_LEVEL` with `level` = 0.
  - Esc: ignored.
- **`S_LEVEL`:**
  - Left/Right: `level` decrements/increments with wrap over `0..NUM_LEVELS-1`.
  - Esc: go to `S_GAME`, `level` = 0, `game` kept.
  - Enter: `GameChoice` = `GAME_BASE + game*NUM_LEVELS + level`, where `GAME_BASE` = 2. `Launch` pulses, and the FSM goes to `S_GAME` with `game`, `level` = 0.
- **`Enable` low:** the FSM is forced to `S_GAME` with `game` = `level` = 0, and no press is acted on. `GameChoice` holds its value, since the launched game runs while the menu is disabled.
- **Pixel classification** (evaluated only when `Enable` is high, otherwise `PixSource` = 0):
  - Inside tile i: `PixSource` = `SRC_TILE`, `PixTile` = i, `PixIndex` = `TILE_W*(y-TILE_Y0) + (x-tileX)`.
  - Inside label i, `S_GAME`, i = `game`: `PixSource` = `SRC_NAME`, `PixIndex` = `LABEL_W*(y-LABEL_Y0) + (x-labelX)`.
  - Inside label i, `S_LEVEL`, i = `game`: the label is split into `NUM_LEVELS` equal segments of width `LABEL_W/NUM_LEVELS`. `PixIndex` uses the same formula. The segment equal to `level` gets `SRC_LVL_SEL`; the other segments get `SRC_LVL`.
  - Everywhere else, and unselected labels: `SRC_NONE`.
- **Reset values:** `S_GAME`, `game` = 0, `level` = 0, `GameChoice` = `MENU_CODE`, `Launch` = 0, `PixSource` = 0, `PixTile` = 0, `PixIndex` = 0, edge registers = 0.
- **Reset mid-operation:** from any state, including mid-`S_LEVEL`, all registers return to their reset values immediately (asynchronous).

## Timing
- A press is detected in the cycle its level first reads high. The state, `game`/`level`, `GameChoice` and `Launch` update at the next rising edge.
- `Launch` is high for exactly one cycle.
- Pixel path latency is one cycle: `PixSource`, `PixTile` and `PixIndex` are registered and correspond to the `VGAx`/`VGAy` of the previous cycle. The colour mux adds the ROM latency separately.
- The pixel path uses the FSM state and selection registers as of the current cycle, so a selection change is visible from the next pixel.
- Index arithmetic is computed at 17 bits and truncated to 13 bits.

## Structure
- Package `menu_pkg`:
  - state enum (`S_GAME`, `S_LEVEL`)
  - pix source enum: `SRC_NONE`=0, `SRC_TILE`=1, `SRC_NAME`=2, `SRC_LVL`=3, `SRC_LVL_SEL`=4
  - constants `MENU_CODE`=1 and `GAME_BASE`=2
- Sub-module `menu_btn_edge`: parametrised-width rising-edge detector with async reset, instanced once over {Left, Right, Enter, Esc}.
- The FSM and the pixel classifier stay in `menu_controller`.

## Test plan
- **Reset, then scan:** reset and hold `Enable` = 1. `GameChoice` = 1, `Launch` = 0. Scanning (20,80) gives `SRC_TILE`, tile 0, index 0, one cycle later.
- **Right wrap:** with defaults, press Right 3 times → `game` cycles 1, 2, 0. The label at (240,190) shows `SRC_NAME` only after the second press.
- **Full launch:** Enter, Right, Enter → `GameChoice` = 2+0*2+1 = 3 and `Launch` high for exactly one cycle. The FSM is back in `S_GAME` with `game` = 0. A second Enter without release does nothing.
- **Escape from level select:** `game` = 2, Enter, then Esc → `S_LEVEL` and then `S_GAME` with `game` = 2 and `GameChoice` still 1. Simultaneous Left+Esc in `S_LEVEL` applies Left only.
- **Enable low mid-selection:** drop `Enable` in `S_LEVEL` → `S_GAME`, `game` = 0, `PixSource` = 0, `GameChoice` holds. Holding Right while re-raising `Enable` causes no move.
- **Async reset mid-selection:** `NUM_GAMES`=4, `NUM_LEVELS`=3, `game` = 3, `level` = 2, Enter → `GameChoice` = 2+3*3+2 = 13. Asserting `Reset` in the middle of a clock period in `S_LEVEL` returns all outputs to reset values before the next edge.
